// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the pixel scan controller:
//   scan_state_t  - controller states (IDLE, SCAN, DONE)
//   SCAN_DIM_W    - default width of image dimension / coordinate fields
//   SCAN_ADDR_W   - default width of the linear pixel address
//   MIN_DIM       - smallest image dimension that holds a full 3x3 window
// -----------------------------------------------------------------------------
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  localparam int SCAN_DIM_W  = 10;
  localparam int SCAN_ADDR_W = 20;
  localparam int MIN_DIM     = 3;

endpackage : scan_pkg

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
// Programmable wrap-around counter. Counts 0..rollover_val and wraps back to 0
// on the enabled edge where the count equals rollover_val.
// Ports:
//   clk           in   clock, rising edge
//   n_rst         in   asynchronous active-low reset (count -> 0)
//   clear         in   synchronous clear to 0, takes priority over counting
//   count_enable  in   advance the count on this edge
//   rollover_val  in   terminal count value
//   count_out     out  current count
//   rollover_flag out  count_out == rollover_val (combinational)
// -----------------------------------------------------------------------------
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  assign rollover_flag = (count_out == rollover_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (rollover_flag) begin
        count_out <= '0;
      end else begin
        count_out <= count_out + NUM_CNT_BITS'(1);
      end
    end
  end

endmodule : flex_counter

// File: rtl/pixel_scan_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_scan_ctrl
// Raster-scan address generator for a 3x3 window filter. After an accepted
// start it walks every pixel of a width x height image in row-major order,
// issuing one read per non-stalled cycle, and flags where a full 3x3 window
// ends.
// Ports:
//   clk         in   clock, rising edge
//   n_rst       in   asynchronous active-low reset
//   start       in   single-cycle frame request (ignored while busy)
//   img_width   in   columns, sampled on an accepted start
//   img_height  in   rows, sampled on an accepted start
//   stall       in   downstream not ready; current pixel is held
//   rd_req      out  pixel read valid this cycle (pixel accepted at next edge)
//   rd_addr     out  linear address row*width + col
//   col, row    out  current pixel coordinates
//   win_valid   out  a complete 3x3 window ends at the current pixel
//   line_end    out  current pixel is the last column of its row
//   frame_done  out  one-cycle pulse after the last pixel is accepted
//   busy        out  scan in progress (SCAN or DONE)
//   cfg_err     out  one-cycle pulse after a start with a dimension < 3
// ADDR_W must be at least 2*DIM_W so the address never wraps within a frame.
// -----------------------------------------------------------------------------
module pixel_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIM_W  = SCAN_DIM_W,
  parameter int ADDR_W = SCAN_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic              stall,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DIM_W-1:0]  col,
  output logic [DIM_W-1:0]  row,
  output logic              win_valid,
  output logic              line_end,
  output logic              frame_done,
  output logic              busy,
  output logic              cfg_err
);

  scan_state_t state, state_nxt;

  logic [DIM_W-1:0] width_lat;
  logic [DIM_W-1:0] height_lat;
  logic [DIM_W-1:0] col_max;
  logic [DIM_W-1:0] row_max;
  logic             dims_ok;
  logic             start_ok;
  logic             start_bad;
  logic             accept;
  logic             col_wrap;
  logic             row_wrap;
  logic             last_pixel;
  logic             in_scan;

  assign dims_ok   = (img_width  >= DIM_W'(MIN_DIM)) &&
                     (img_height >= DIM_W'(MIN_DIM));
  assign start_ok  = (state == ST_IDLE) && start &&  dims_ok;
  assign start_bad = (state == ST_IDLE) && start && !dims_ok;

  assign col_max = width_lat  - DIM_W'(1);
  assign row_max = height_lat - DIM_W'(1);

  assign in_scan    = (state == ST_SCAN);
  assign accept     = rd_req;
  // col_wrap/row_wrap are the counters' terminal-count flags; gating with
  // the state keeps line_end low outside a scan.
  assign line_end   = in_scan && col_wrap;
  assign last_pixel = accept && col_wrap && row_wrap;
  assign win_valid  = rd_req && (row >= DIM_W'(2)) && (col >= DIM_W'(2));

  flex_counter #(
    .NUM_CNT_BITS (DIM_W)
  ) u_col_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (start_ok),
    .count_enable  (accept),
    .rollover_val  (col_max),
    .count_out     (col),
    .rollover_flag (col_wrap)
  );

  flex_counter #(
    .NUM_CNT_BITS (DIM_W)
  ) u_row_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (start_ok),
    .count_enable  (accept && line_end),
    .rollover_val  (row_max),
    .count_out     (row),
    .rollover_flag (row_wrap)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_req     = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy   = 1'b1;
        rd_req = !stall;
        if (last_pixel) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Dimensions are latched only on an accepted start so a start pulsed
  // mid-frame cannot disturb the running scan.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      width_lat  <= '0;
      height_lat <= '0;
    end else if (start_ok) begin
      width_lat  <= img_width;
      height_lat <= img_height;
    end
  end

  // Row-major order makes the linear address a plain running count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_addr <= '0;
    end else if (start_ok) begin
      rd_addr <= '0;
    end else if (accept) begin
      rd_addr <= rd_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= start_bad;
    end
  end

endmodule : pixel_scan_ctrl
